exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_if.sv | 28 ++
 rtl/exec_sequencer.sv | 148 ++++++++++++++
 tb/tb_exec_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// Handshake bundle between the control FSM, the ALU/converter datapath and exec_sequencer.
// The slave modport is the sequencer's view; the master modport is the driver's view.
interface exec_sequencer_if;
    logic       ex_req;
    logic       clear_req;
    logic [1:0] opcode;
    logic       b_zero;
    logic       alu_done;
    logic       conv_done;
    logic [1:0] op_out;
    logic       alu_start;
    logic       conv_start;
    logic       load_result;
    logic       done_strobe;
    logic       busy;
    logic       error;
    logic [1:0] err_code;

    modport master (
        output ex_req, clear_req, opcode, b_zero, alu_done, conv_done,
        input  op_out, alu_start, conv_start, load_result, done_strobe, busy, error, err_code
    );

    modport slave (
        input  ex_req, clear_req, opcode, b_zero, alu_done, conv_done,
        output op_out, alu_start, conv_start, load_result, done_strobe, busy, error, err_code
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute sequencer: start ALU, then BCD converter, load and signal completion,
// with per-stage timeouts, divide-by-zero trapping and a sticky error code.
module exec_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    exec_sequencer_if.slave    sif
);

    typedef enum logic [2:0] {
        IDLE,
        ALU_WAIT,
        CONV_WAIT,
        LOAD,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] op_out_q, op_out_d;
    logic       alu_start_q, alu_start_d;
    logic       conv_start_q, conv_start_d;
    logic       load_result_q, load_result_d;
    logic       done_strobe_q, done_strobe_d;
    logic       busy_q, busy_d;
    logic       error_q, error_d;
    logic [1:0] err_code_q, err_code_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_out_d      = op_out_q;
        alu_start_d   = 1'b0;
        conv_start_d  = 1'b0;
        load_result_d = 1'b0;
        done_strobe_d = 1'b0;
        error_d       = error_q;
        err_code_d    = err_code_q;

        // clear_req outranks every other event in the same cycle
        if (sif.clear_req) begin
            state_d    = IDLE;
            cnt_d      = '0;
            error_d    = 1'b0;
            err_code_d = '0;
        end else begin
            unique case (state_q)
                IDLE, ERR: begin
                    if (sif.ex_req) begin
                        op_out_d   = sif.opcode;
                        cnt_d      = '0;
                        error_d    = 1'b0;
                        err_code_d = '0;
                        if (sif.opcode == 2'b11 && sif.b_zero) begin
                            state_d    = ERR;
                            error_d    = 1'b1;
                            err_code_d = 2'b01;
                        end else begin
                            state_d     = ALU_WAIT;
                            alu_start_d = 1'b1;
                        end
                    end
                end
                ALU_WAIT: begin
                    if (sif.alu_done) begin
                        state_d      = CONV_WAIT;
                        conv_start_d = 1'b1;
                        cnt_d        = '0;
                    end else if (cnt_q == LIMIT) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'b10;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                CONV_WAIT: begin
                    if (sif.conv_done) begin
                        state_d       = LOAD;
                        load_result_d = 1'b1;
                        cnt_d         = '0;
                    end else if (cnt_q == LIMIT) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'b11;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                LOAD: begin
                    state_d       = DONE;
                    done_strobe_d = 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == ALU_WAIT) || (state_d == CONV_WAIT) ||
                 (state_d == LOAD) || (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_out_q      <= '0;
            alu_start_q   <= 1'b0;
            conv_start_q  <= 1'b0;
            load_result_q <= 1'b0;
            done_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_out_q      <= op_out_d;
            alu_start_q   <= alu_start_d;
            conv_start_q  <= conv_start_d;
            load_result_q <= load_result_d;
            done_strobe_q <= done_strobe_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign sif.op_out      = op_out_q;
    assign sif.alu_start   = alu_start_q;
    assign sif.conv_start  = conv_start_q;
    assign sif.load_result = load_result_q;
    assign sif.done_strobe = done_strobe_q;
    assign sif.busy        = busy_q;
    assign sif.error       = error_q;
    assign sif.err_code    = err_code_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: each operation is planned as a timeline of
// expected output events; a negedge monitor pops and compares them as they appear.
module tb_exec_sequencer;

    localparam int TO    = 64;
    localparam int NEVER = TO + 1;

    localparam int EV_ALU  = 0;
    localparam int EV_CONV = 1;
    localparam int EV_LOAD = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    typedef struct {
        int kind;
        int cyc;
        int op;
        int code;
    } ev_t;

    logic clock;
    logic reset_n;
    int   cyc;
    int   nvec;
    int   nerr;
    logic err_prev;
    ev_t  exq[$];

    // Reference state the model expects the block to sit in between operations
    int   op_cur;
    bit   err_exp;
    int   code_exp;

    exec_sequencer_if sif ();

    exec_sequencer #(.TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sif     (sif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic ev_t mk(input int kind, input int c, input int op, input int code);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.op   = op;
        e.code = code;
        return e;
    endfunction

    task automatic expect_ev(input int kind);
        ev_t e;
        if (exq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e = exq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_op_out", int'(sif.op_out), e.op);
            check("event_busy", int'(sif.busy), (kind == EV_ERR) ? 0 : 1);
            if (kind == EV_ERR) check("event_err_code", int'(sif.err_code), e.code);
        end
    endtask

    initial err_prev = 1'b0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (sif.alu_start)              expect_ev(EV_ALU);
            if (sif.conv_start)             expect_ev(EV_CONV);
            if (sif.load_result)            expect_ev(EV_LOAD);
            if (sif.done_strobe)            expect_ev(EV_DONE);
            if (sif.error && !err_prev)     expect_ev(EV_ERR);
        end
        err_prev = sif.error;
    end

    task automatic idle_inputs();
        sif.ex_req    = 1'b0;
        sif.clear_req = 1'b0;
        sif.alu_done  = 1'b0;
        sif.conv_done = 1'b0;
        sif.opcode    = 2'b00;
        sif.b_zero    = 1'b0;
    endtask

    task automatic idle_check();
        check("idle_busy", int'(sif.busy), 0);
        check("idle_error", int'(sif.error), int'(err_exp));
        check("idle_err_code", int'(sif.err_code), code_exp);
        check("idle_op_out", int'(sif.op_out), op_cur);
    endtask

    // a: offset of alu_done after ex_req; b: offset of conv_done after alu_done
    // (values > TO mean the done never arrives); k: clear_req offset or -1;
    // clr_ex: clear_req together with ex_req; spur: percent of ignored extra strobes.
    task automatic run_op(input logic [1:0] op, input logic bz, input int a, input int b,
                          input int k, input bit clr_ex, input int spur);
        int  t0, last, endo, ecode;
        bit  a_ok, b_ok, div0, cleared;
        ev_t plan[$];

        t0    = cyc;
        div0  = (op == 2'b11) && bz && !clr_ex;
        a_ok  = (a <= TO);
        b_ok  = (b <= TO);
        ecode = 0;
        last  = 0;

        if (clr_ex) begin
            last = 0;
        end else if (div0) begin
            plan.push_back(mk(EV_ERR, t0 + 1, op, 1));
            last  = 1;
            ecode = 1;
        end else begin
            plan.push_back(mk(EV_ALU, t0 + 1, op, 0));
            if (!a_ok) begin
                plan.push_back(mk(EV_ERR, t0 + TO + 1, op, 2));
                last  = TO + 1;
                ecode = 2;
            end else begin
                plan.push_back(mk(EV_CONV, t0 + a + 1, op, 0));
                if (!b_ok) begin
                    plan.push_back(mk(EV_ERR, t0 + a + TO + 1, op, 3));
                    last  = a + TO + 1;
                    ecode = 3;
                end else begin
                    plan.push_back(mk(EV_LOAD, t0 + a + b + 1, op, 0));
                    plan.push_back(mk(EV_DONE, t0 + a + b + 2, op, 0));
                    last = a + b + 2;
                end
            end
        end

        cleared = !clr_ex && (k >= 1) && (k <= last);
        endo    = cleared ? k : last;
        foreach (plan[i]) if (plan[i].cyc - t0 <= endo) exq.push_back(plan[i]);

        if (!clr_ex) op_cur = int'(op);
        if (clr_ex || cleared) begin
            err_exp  = 1'b0;
            code_exp = 0;
        end else begin
            err_exp  = (ecode != 0);
            code_exp = ecode;
        end

        for (int off = 0; off <= endo; off++) begin
            sif.ex_req    = 1'b0;
            sif.clear_req = 1'b0;
            sif.alu_done  = 1'b0;
            sif.conv_done = 1'b0;
            sif.opcode    = 2'($urandom);
            sif.b_zero    = 1'($urandom);
            if (off == 0) begin
                sif.ex_req    = 1'b1;
                sif.opcode    = op;
                sif.b_zero    = bz;
                sif.clear_req = clr_ex;
            end else begin
                if (!div0 && !clr_ex) begin
                    if (a_ok && off == a) sif.alu_done = 1'b1;
                    if (a_ok && b_ok && off == a + b) sif.conv_done = 1'b1;
                    if (off < last && $urandom_range(0, 99) < spur) begin
                        sif.ex_req = 1'b1;
                        if (!a_ok || off <= a) sif.conv_done = 1'b1;
                        else sif.alu_done = 1'b1;
                    end
                end
                if (cleared && off == k) sif.clear_req = 1'b1;
            end
            @(negedge clock);
        end

        idle_inputs();
        repeat ($urandom_range(0, 2)) @(negedge clock);
        idle_check();
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 99);
        if (r < 75) return $urandom_range(1, 5);
        if (r < 85) return TO;
        if (r < 90) return TO - 1;
        return NEVER;
    endfunction

    task automatic reset_mid_op();
        int t0;
        t0 = cyc;
        exq.push_back(mk(EV_ALU, t0 + 1, 1, 0));
        sif.ex_req = 1'b1;
        sif.opcode = 2'b01;
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("reset_async_outputs",
              int'({sif.op_out, sif.alu_start, sif.conv_start, sif.load_result,
                    sif.done_strobe, sif.busy, sif.error, sif.err_code}), 0);
        @(negedge clock);
        check("reset_held_busy", int'(sif.busy), 0);
        reset_n = 1'b1;
        op_cur   = 0;
        err_exp  = 1'b0;
        code_exp = 0;
        repeat (3) begin
            sif.alu_done  = 1'b1;
            sif.conv_done = 1'b1;
            @(negedge clock);
        end
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        idle_check();
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        op_cur   = 0;
        err_exp  = 1'b0;
        code_exp = 0;
        reset_n  = 1'b0;
        idle_inputs();
        #2;
        check("reset_outputs",
              int'({sif.op_out, sif.alu_start, sif.conv_start, sif.load_result,
                    sif.done_strobe, sif.busy, sif.error, sif.err_code}), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        idle_check();

        run_op(2'b10, 1'b0, 3, 2, -1, 1'b0, 0);
        run_op(2'b11, 1'b1, 1, 1, -1, 1'b0, 0);
        run_op(2'b00, 1'b0, 1, 1, -1, 1'b0, 0);
        run_op(2'b01, 1'b0, NEVER, 1, -1, 1'b0, 0);
        run_op(2'b00, 1'b0, TO, 1, -1, 1'b0, 0);
        run_op(2'b10, 1'b0, 2, NEVER, -1, 1'b0, 0);
        run_op(2'b01, 1'b0, 1, TO, -1, 1'b0, 0);
        run_op(2'b01, 1'b0, 2, 3, 5, 1'b0, 0);
        run_op(2'b10, 1'b0, 4, 3, -1, 1'b0, 100);
        run_op(2'b11, 1'b0, 1, 1, -1, 1'b1, 0);
        reset_mid_op();

        for (int n = 0; n < 120; n++) begin
            logic [1:0] op;
            logic       bz;
            int         a, b, k, cl;
            bit         clr_ex;
            op = 2'($urandom);
            bz = ($urandom_range(0, 2) == 0);
            if (err_exp && op == 2'b11) bz = 1'b0;
            a      = pick_delay();
            b      = pick_delay();
            cl     = $urandom_range(0, 99);
            k      = -1;
            clr_ex = 1'b0;
            if (cl < 8) clr_ex = 1'b1;
            else if (cl < 14 && a <= TO && b <= TO) k = a + b;
            else if (cl < 24) k = $urandom_range(1, 12);
            run_op(op, bz, a, b, k, clr_ex, ($urandom_range(0, 1) == 1) ? 20 : 0);
        end

        repeat (3) @(negedge clock);
        check("events_outstanding", exq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
